// File: rtl/bcd_to_binary_seq_pkg.sv
// rtl/bcd_to_binary_seq_pkg.sv - shared sizes, FSM states and digit check for the BCD-to-binary converter
package bcd_pkg;

  localparam int BCD_DIGITS  = 3;
  localparam int DIGIT_W     = 4;
  localparam int BIN_W       = 10;
  localparam int ITER_N      = BIN_W;
  localparam int SREG_W      = DIGIT_W * BCD_DIGITS + BIN_W;
  localparam int CNT_W       = 4;
  localparam int DIGIT_MAX   = 9;
  localparam int CORR_THRESH = 8;
  localparam int CORR_SUB    = 3;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } bcd_state_t;

  function automatic logic digits_valid(input logic [DIGIT_W*BCD_DIGITS-1:0] digits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (digits[DIGIT_W*i +: DIGIT_W] > DIGIT_W'(DIGIT_MAX)) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// rtl/bcd_to_binary_seq_if.sv - request/result bundle between a requester and the converter
interface bcd_to_binary_seq_if;
  import bcd_pkg::*;

  logic               start;
  logic [DIGIT_W-1:0] hundreds;
  logic [DIGIT_W-1:0] tens;
  logic [DIGIT_W-1:0] ones;
  logic [BIN_W-1:0]   binary_out;
  logic               done;
  logic               busy;
  logic               err;

  modport master (
    output start, hundreds, tens, ones,
    input  binary_out, done, busy, err
  );

  modport slave (
    input  start, hundreds, tens, ones,
    output binary_out, done, busy, err
  );

endinterface

// File: rtl/bcd_to_binary_seq_digit_corr.sv
// rtl/bcd_to_binary_seq_digit_corr.sv - per-digit correction step of reverse double-dabble
module bcd_digit_corr
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  assign dout = (din >= DIGIT_W'(CORR_THRESH)) ? din - DIGIT_W'(CORR_SUB) : din;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// rtl/bcd_to_binary_seq.sv - sequential 3-digit BCD to 10-bit binary converter, one bit per clock
module bcd_to_binary_seq
  import bcd_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  bcd_to_binary_seq_if.slave  bus
);

  bcd_state_t                      state, state_nxt;
  logic [SREG_W-1:0]               sreg;
  logic [SREG_W-1:0]               shifted;
  logic [SREG_W-1:0]               corrected;
  logic [CNT_W-1:0]                iter_cnt;
  logic [BIN_W-1:0]                bin_q;
  logic                            err_q;
  logic [DIGIT_W*BCD_DIGITS-1:0]   digits;
  logic                            last_iter;
  logic                            load, reject, step, finish;

  assign digits    = {bus.hundreds, bus.tens, bus.ones};
  assign shifted   = sreg >> 1;
  assign last_iter = (iter_cnt == CNT_W'(ITER_N - 1));

  // Binary bits pass straight through; only the BCD fields get corrected.
  assign corrected[BIN_W-1:0] = shifted[BIN_W-1:0];
  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_corr
    bcd_digit_corr u_corr (
      .din  (shifted  [BIN_W + DIGIT_W*i +: DIGIT_W]),
      .dout (corrected[BIN_W + DIGIT_W*i +: DIGIT_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    reject    = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (digits_valid(digits)) begin
            load      = 1'b1;
            state_nxt = CONV;
          end else begin
            reject    = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      CONV: begin
        step = 1'b1;
        if (last_iter) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg     <= '0;
      iter_cnt <= '0;
      bin_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (load) begin
        sreg     <= SREG_W'(digits) << BIN_W;
        iter_cnt <= '0;
      end else if (step) begin
        sreg     <= corrected;
        // Clearing on the last step keeps the counter from ever wrapping.
        iter_cnt <= last_iter ? '0 : iter_cnt + CNT_W'(1);
      end
      if (finish) begin
        bin_q <= corrected[BIN_W-1:0];
        err_q <= 1'b0;
      end else if (reject) begin
        bin_q <= '0;
        err_q <= 1'b1;
      end
    end
  end

  assign bus.binary_out = bin_q;
  assign bus.err        = err_q;
  assign bus.done       = (state == DONE);
  assign bus.busy       = (state != IDLE);

endmodule
